// File: rtl/psychogenic_neptune_proportional_if.sv
`timescale 1ns/1ps
// Tile pin bundle for the guitar tuner: dedicated inputs, segment outputs
// and the (unused) bidirectional bank.
interface psychogenic_neptune_proportional_if;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena;

  modport master (
    output ui_in,
    output uio_in,
    output ena,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ui_in,
    input  uio_in,
    input  ena,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/psychogenic_neptune_proportional.sv
`timescale 1ns/1ps
// Guitar-string tuner: counts string edges over a one-second gate, matches the
// count to the nearest standard-tuning note and drives a muxed 7-seg digit pair.
module psychogenic_neptune_proportional (
  input  logic                                 clk,
  input  logic                                 rst_n,
  psychogenic_neptune_proportional_if.slave    bus
);

  typedef enum logic [2:0] {
    NOTE_NONE,
    NOTE_E2,
    NOTE_A2,
    NOTE_D3,
    NOTE_G3,
    NOTE_B3,
    NOTE_E4
  } note_e;

  localparam logic [9:0] EDGE_MAX = 10'h3FF;

  // ---------------------------------------------------------------------------
  // Input decode
  // ---------------------------------------------------------------------------
  logic [2:0] clk_config;
  logic       input_pulse;
  logic       display_single_enable;
  logic       display_single_select;

  assign clk_config            = bus.ui_in[4:2];
  assign input_pulse           = bus.ui_in[5];
  assign display_single_enable = bus.ui_in[6];
  assign display_single_select = bus.ui_in[7];

  logic unused_inputs;
  assign unused_inputs = &{1'b0, bus.ena, bus.uio_in, bus.ui_in[1:0]};

  // ---------------------------------------------------------------------------
  // Classification helpers
  // ---------------------------------------------------------------------------
  function automatic note_e classify(input logic [9:0] c);
    if      (c >= 10'd60  && c <= 10'd95)  return NOTE_E2;
    else if (c >= 10'd96  && c <= 10'd128) return NOTE_A2;
    else if (c >= 10'd129 && c <= 10'd171) return NOTE_D3;
    else if (c >= 10'd172 && c <= 10'd221) return NOTE_G3;
    else if (c >= 10'd222 && c <= 10'd288) return NOTE_B3;
    else if (c >= 10'd289 && c <= 10'd400) return NOTE_E4;
    return NOTE_NONE;
  endfunction

  function automatic logic [9:0] target_of(input note_e n);
    case (n)
      NOTE_E2: return 10'd82;
      NOTE_A2: return 10'd110;
      NOTE_D3: return 10'd147;
      NOTE_G3: return 10'd196;
      NOTE_B3: return 10'd247;
      NOTE_E4: return 10'd330;
      default: return 10'd0;
    endcase
  endfunction

  function automatic logic [6:0] note_glyph_of(input note_e n);
    case (n)
      NOTE_E2: return 7'h79;
      NOTE_A2: return 7'h77;
      NOTE_D3: return 7'h5E;
      NOTE_G3: return 7'h3D;
      NOTE_B3: return 7'h7C;
      NOTE_E4: return 7'h7B;
      default: return 7'h40;
    endcase
  endfunction

  // Seven-step sharp/flat bar: left segments for flat, right for sharp,
  // middle bar alone means in tune.
  function automatic logic [6:0] prox_glyph_of(input note_e n, input logic [9:0] c);
    logic signed [10:0] d;
    if (n == NOTE_NONE) return 7'h00;
    d = $signed({1'b0, c}) - $signed({1'b0, target_of(n)});
    if      (d <= -11'sd8) return 7'h30;
    else if (d <= -11'sd4) return 7'h10;
    else if (d <= -11'sd2) return 7'h50;
    else if (d <=  11'sd1) return 7'h40;
    else if (d <=  11'sd3) return 7'h44;
    else if (d <=  11'sd7) return 7'h04;
    return 7'h06;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0]  cfg_q;
  logic [23:0] gate_len;
  logic [23:0] gate_cnt;
  logic        cfg_change;
  logic        gate_end;

  logic [1:0]  pulse_sync;
  logic        pulse_prev;
  logic        rise;
  logic [9:0]  edge_cnt;
  logic [9:0]  edge_total;

  logic [6:0]  note_glyph;
  logic [6:0]  prox_glyph;
  logic [6:0]  note_glyph_next;
  logic [6:0]  prox_glyph_next;
  note_e       cls_note;

  logic [2:0]  mux_cnt;
  logic        mux_sel;
  logic        show_prox;
  logic [6:0]  seg_q;
  logic        prox_select_q;

  always_comb begin
    case (cfg_q)
      3'd0:    gate_len = 24'd1000;
      3'd1:    gate_len = 24'd2000;
      3'd2:    gate_len = 24'd4000;
      3'd3:    gate_len = 24'd10000;
      3'd4:    gate_len = 24'd32768;
      3'd5:    gate_len = 24'd100000;
      3'd6:    gate_len = 24'd1000000;
      default: gate_len = 24'd10000000;
    endcase
  end

  // A config change wins over a coinciding gate end so the partial window
  // measured at the old rate is never reported.
  assign cfg_change = (clk_config != cfg_q);
  assign gate_end   = !cfg_change && (gate_cnt == gate_len - 24'd1);

  assign rise       = pulse_sync[1] & ~pulse_prev;
  assign edge_total = (edge_cnt == EDGE_MAX) ? edge_cnt : edge_cnt + {9'd0, rise};

  assign cls_note        = classify(edge_total);
  assign note_glyph_next = gate_end ? note_glyph_of(cls_note) : note_glyph;
  assign prox_glyph_next = gate_end ? prox_glyph_of(cls_note, edge_total) : prox_glyph;

  assign show_prox = display_single_enable ? display_single_select : mux_sel;

  // The reset pin keeps its tile name but is active-high here.
  // NOTE: every register, including the glyph latches, is reset so the display
  // is guaranteed blank until a full gate has been measured.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      cfg_q         <= '0;
      gate_cnt      <= '0;
      pulse_sync    <= '0;
      pulse_prev    <= 1'b0;
      edge_cnt      <= '0;
      note_glyph    <= '0;
      prox_glyph    <= '0;
      mux_cnt       <= '0;
      mux_sel       <= 1'b0;
      seg_q         <= '0;
      prox_select_q <= 1'b0;
    end else begin
      cfg_q      <= clk_config;
      pulse_sync <= {pulse_sync[0], input_pulse};
      pulse_prev <= pulse_sync[1];

      if (cfg_change || gate_end) begin
        gate_cnt <= '0;
        edge_cnt <= '0;
      end else begin
        gate_cnt <= gate_cnt + 24'd1;
        edge_cnt <= edge_total;
      end

      if (gate_end) begin
        note_glyph <= note_glyph_next;
        prox_glyph <= prox_glyph_next;
      end

      mux_cnt <= mux_cnt + 3'd1;
      if (mux_cnt == 3'd7) mux_sel <= ~mux_sel;

      // Output stage reads the next glyph values so a new result is shown
      // on the very first cycle of the following gate.
      seg_q         <= show_prox ? prox_glyph_next : note_glyph_next;
      prox_select_q <= show_prox;
    end
  end

  assign bus.uo_out  = {prox_select_q, seg_q};
  assign bus.uio_out = 8'h00;
  assign bus.uio_oe  = 8'h00;

endmodule

// File: tb/tb_psychogenic_neptune_proportional.sv
`timescale 1ns/1ps
// Directed bench for the guitar tuner: evenly spaced edge streams at N = 1000,
// expected digit pairs queued on stimulus and popped on readback.
module tb_psychogenic_neptune_proportional;

  typedef struct {
    string      tag;
    logic [7:0] uo;
  } exp_t;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b1;
  logic [2:0] cfg        = 3'd0;
  logic       pulse      = 1'b0;
  logic       single_en  = 1'b1;
  logic       single_sel = 1'b0;

  int edges_per_gate = 0;
  int acc            = 0;
  int checks         = 0;
  int errors         = 0;
  exp_t sb[$];

  psychogenic_neptune_proportional_if bus();
  assign bus.ui_in  = {single_sel, single_en, pulse, cfg, 2'b00};
  assign bus.uio_in = 8'h00;
  assign bus.ena    = 1'b1;

  psychogenic_neptune_proportional dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Phase accumulator: exactly edges_per_gate isolated one-cycle highs in
  // every window of 1000 consecutive cycles.
  initial forever begin
    @(negedge clk);
    acc = acc + edges_per_gate;
    if (acc >= 1000) begin
      acc   = acc - 1000;
      pulse = 1'b1;
    end else begin
      pulse = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pair(input string tag, input logic [6:0] note, input logic [6:0] prox);
    exp_t e;
    e.tag = {tag, "_note"};
    e.uo  = {1'b0, note};
    sb.push_back(e);
    e.tag = {tag, "_prox"};
    e.uo  = {1'b1, prox};
    sb.push_back(e);
  endtask

  task automatic read_back();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      single_sel = e.uo[7];
      @(negedge clk);
      check(e.tag, bus.uo_out, e.uo);
    end
  endtask

  task automatic run_case(input string tag, input int k, input logic [6:0] note, input logic [6:0] prox);
    edges_per_gate = k;
    wait_cycles(2100);
    expect_pair(tag, note, prox);
    read_back();
  endtask

  initial begin
    int   prev_ps;
    int   ps;
    int   last_edge;
    int   intervals;

    // Reset and blank display before any gate completes
    rst_n = 1'b1;
    wait_cycles(5);
    rst_n = 1'b0;
    wait_cycles(2);
    check("uio_out", bus.uio_out, 8'h00);
    check("uio_oe", bus.uio_oe, 8'h00);
    expect_pair("reset", 7'h00, 7'h00);
    read_back();

    run_case("a2_110", 110, 7'h77, 7'h40);
    run_case("a2_100", 100, 7'h77, 7'h30);
    run_case("e4_335", 335, 7'h7B, 7'h04);
    run_case("e2_84",   84, 7'h79, 7'h44);
    run_case("none_500", 500, 7'h40, 7'h00);
    run_case("none_0",    0, 7'h40, 7'h00);

    // Multiplex mode at G3 in tune
    edges_per_gate = 196;
    wait_cycles(2100);
    single_en = 1'b0;
    wait_cycles(2);
    prev_ps   = -1;
    last_edge = -1;
    intervals = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      ps = int'(bus.uo_out[7]);
      check("mux_seg", bus.uo_out, (ps == 1) ? 8'hC0 : 8'h3D);
      if (prev_ps >= 0 && ps != prev_ps) begin
        if (last_edge >= 0) begin
          check_int("mux_period", i - last_edge, 8);
          intervals++;
        end
        last_edge = i;
      end
      prev_ps = ps;
    end
    check_int("mux_intervals_seen", (intervals >= 6) ? 1 : 0, 1);
    single_en = 1'b1;

    // Reset mid-gate with a steady A2 stream
    edges_per_gate = 110;
    wait_cycles(2100);
    wait_cycles(317);
    rst_n = 1'b1;
    wait_cycles(3);
    rst_n = 1'b0;
    expect_pair("rst_mid", 7'h00, 7'h00);
    read_back();
    wait_cycles(978);
    expect_pair("rst_still_blank", 7'h00, 7'h00);
    sb.pop_back();
    read_back();
    wait_cycles(30);
    expect_pair("rst_first_gate", 7'h77, 7'h40);
    read_back();

    // Config change mid-gate restarts the window at the new length
    wait_cycles(1500);
    wait_cycles(123);
    cfg = 3'd1;
    wait_cycles(1985);
    expect_pair("cfg_hold", 7'h77, 7'h40);
    sb.pop_back();
    read_back();
    wait_cycles(40);
    expect_pair("cfg_g3_220", 7'h3D, 7'h06);
    read_back();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
